// File: rtl/alu_share_arb_if.sv
// Requester A/B operand channels, shared-ALU drive/return and response bundle for alu_share_arb.
// slave = arbiter side, master = requesters/ALU/response-sink side.
interface alu_share_arb_if #(
  parameter int WIDTH = 128,
  parameter int OPW   = 4
) ();
  logic             a_valid;
  logic             a_ready;
  logic [OPW-1:0]   a_op;
  logic [WIDTH-1:0] a_x;
  logic [WIDTH-1:0] a_y;

  logic             b_valid;
  logic             b_ready;
  logic [OPW-1:0]   b_op;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH-1:0] b_y;

  logic             alu_sel;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  logic             alu_start;
  logic [WIDTH-1:0] alu_result;

  logic             resp_valid;
  logic             resp_id;
  logic [WIDTH-1:0] resp_data;

  modport slave (
    input  a_valid, a_op, a_x, a_y,
    input  b_valid, b_op, b_x, b_y,
    input  alu_result,
    output a_ready, b_ready,
    output alu_sel, alu_op, alu_x, alu_y, alu_start,
    output resp_valid, resp_id, resp_data
  );

  modport master (
    output a_valid, a_op, a_x, a_y,
    output b_valid, b_op, b_x, b_y,
    output alu_result,
    input  a_ready, b_ready,
    input  alu_sel, alu_op, alu_x, alu_y, alu_start,
    input  resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin share of one fixed-latency ALU between A and B; accept-to-accept ALU_LAT+3 cycles, responses have no backpressure.
// Define ALU_SHARE_STATS_EN to add saturating 32-bit per-requester grant counters.
module alu_share_arb #(
  parameter int WIDTH   = 128,
  parameter int OPW     = 4,
  parameter int ALU_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
`ifdef ALU_SHARE_STATS_EN
  output logic [31:0] grant_cnt_a,
  output logic [31:0] grant_cnt_b,
`endif
  alu_share_arb_if.slave bus
);

  localparam int CW = $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic [CW-1:0]    cnt;
  logic             grant_a;
  logic             grant_b;

  logic             sel_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic             id_q;
  logic [WIDTH-1:0] data_q;

  // last_grant==1 means B was served last, so A wins a tie
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == IDLE && !rst) begin
      grant_a = bus.a_valid && (!bus.b_valid || last_grant);
      grant_b = bus.b_valid && (!bus.a_valid || !last_grant);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_a || grant_b) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.a_ready    = grant_a;
    bus.b_ready    = grant_b;
    bus.alu_start  = (state == ISSUE);
    bus.resp_valid = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      cnt        <= '0;
      sel_q      <= 1'b0;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      id_q       <= 1'b0;
      data_q     <= '0;
    end else begin
      if (grant_a || grant_b) begin
        sel_q      <= grant_b;
        op_q       <= grant_b ? bus.b_op : bus.a_op;
        x_q        <= grant_b ? bus.b_x  : bus.a_x;
        y_q        <= grant_b ? bus.b_y  : bus.a_y;
        last_grant <= grant_b;
      end
      if (state == ISSUE)
        cnt <= CW'(ALU_LAT - 1);
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - CW'(1);
      // result is valid exactly in the last WAIT cycle
      if (state == WAIT && cnt == '0) begin
        data_q <= bus.alu_result;
        id_q   <= sel_q;
      end
    end
  end

  assign bus.alu_sel   = sel_q;
  assign bus.alu_op    = op_q;
  assign bus.alu_x     = x_q;
  assign bus.alu_y     = y_q;
  assign bus.resp_id   = id_q;
  assign bus.resp_data = data_q;

`ifdef ALU_SHARE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_a <= '0;
      grant_cnt_b <= '0;
    end else begin
      if (grant_a && grant_cnt_a != 32'hFFFF_FFFF) grant_cnt_a <= grant_cnt_a + 32'd1;
      if (grant_b && grant_cnt_b != 32'hFFFF_FFFF) grant_cnt_b <= grant_cnt_b + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: ALU_LAT=2 and ALU_LAT=1 instances, pipelined ALU model, response scoreboards.
`timescale 1ns/1ps
module tb_alu_share_arb;
  localparam int W  = 128;
  localparam int OW = 4;
  localparam logic [W-1:0] JUNK = {4{32'hDEAD_BEEF}};

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  exp_t q2[$];
  exp_t q1[$];

  alu_share_arb_if #(.WIDTH(W), .OPW(OW)) i2 ();
  alu_share_arb_if #(.WIDTH(W), .OPW(OW)) i1 ();

`ifdef ALU_SHARE_STATS_EN
  logic [31:0] gca2, gcb2, gca1, gcb1;
`endif

  alu_share_arb #(.WIDTH(W), .OPW(OW), .ALU_LAT(2)) dut2 (
    .clk(clk),
    .rst(rst),
`ifdef ALU_SHARE_STATS_EN
    .grant_cnt_a(gca2),
    .grant_cnt_b(gcb2),
`endif
    .bus(i2.slave)
  );

  alu_share_arb #(.WIDTH(W), .OPW(OW), .ALU_LAT(1)) dut1 (
    .clk(clk),
    .rst(rst),
`ifdef ALU_SHARE_STATS_EN
    .grant_cnt_a(gca1),
    .grant_cnt_b(gcb1),
`endif
    .bus(i1.slave)
  );

  function automatic logic [W-1:0] alu_f(input logic [OW-1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    case (op)
      4'd0:    return x + y;
      4'd1:    return x - y;
      4'd2:    return x ^ y;
      default: return x & y;
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ALU model: result only meaningful exactly ALU_LAT cycles after alu_start
  logic [W-1:0] s2_0 = JUNK, s2_1 = JUNK, s1_0 = JUNK;
  always @(posedge clk) begin
    s2_0 <= i2.alu_start ? alu_f(i2.alu_op, i2.alu_x, i2.alu_y) : JUNK;
    s2_1 <= s2_0;
    s1_0 <= i1.alu_start ? alu_f(i1.alu_op, i1.alu_x, i1.alu_y) : JUNK;
  end
  assign i2.alu_result = s2_1;
  assign i1.alu_result = s1_0;

  // scoreboards: expectation pushed at acceptance, popped at response
  always @(negedge clk) begin
    exp_t e;
    if (i2.resp_valid) begin
      check("d2_resp_pending", (q2.size() != 0), 1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        check("d2_resp_id", i2.resp_id, e.id);
        check("d2_resp_data", i2.resp_data, e.data);
      end
    end
    if (i2.a_valid && i2.a_ready) q2.push_back('{1'b0, alu_f(i2.a_op, i2.a_x, i2.a_y)});
    if (i2.b_valid && i2.b_ready) q2.push_back('{1'b1, alu_f(i2.b_op, i2.b_x, i2.b_y)});
    if (i1.resp_valid) begin
      check("d1_resp_pending", (q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("d1_resp_id", i1.resp_id, e.id);
        check("d1_resp_data", i1.resp_data, e.data);
      end
    end
    if (i1.a_valid && i1.a_ready) q1.push_back('{1'b0, alu_f(i1.a_op, i1.a_x, i1.a_y)});
    if (i1.b_valid && i1.b_ready) q1.push_back('{1'b1, alu_f(i1.b_op, i1.b_x, i1.b_y)});
  end

  task automatic drain2();
    for (int c = 0; c < 30 && q2.size() != 0; c++) tick();
    check("d2_drain", q2.size(), 0);
    tick();
  endtask

  task automatic drain1();
    for (int c = 0; c < 30 && q1.size() != 0; c++) tick();
    check("d1_drain", q1.size(), 0);
    tick();
  endtask

  // single request on dut2; waits (bounded) for acceptance
  task automatic req2(input logic id, input logic [OW-1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int c;
    if (id) begin i2.b_op = op; i2.b_x = x; i2.b_y = y; i2.b_valid = 1'b1; end
    else    begin i2.a_op = op; i2.a_x = x; i2.a_y = y; i2.a_valid = 1'b1; end
    #1;
    c = 0;
    while (!(id ? i2.b_ready : i2.a_ready) && c < 20) begin tick(); c++; end
    check("req2_accept_in_time", (c < 20), 1);
    tick();
    i2.a_valid = 1'b0;
    i2.b_valid = 1'b0;
  endtask

  int   gcyc[$];
  logic gid[$];
  logic got_g, acc_b;
  int   busy_resp;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i2.a_valid = 0; i2.a_op = '0; i2.a_x = '0; i2.a_y = '0;
    i2.b_valid = 0; i2.b_op = '0; i2.b_x = '0; i2.b_y = '0;
    i1.a_valid = 0; i1.a_op = '0; i1.a_x = '0; i1.a_y = '0;
    i1.b_valid = 0; i1.b_op = '0; i1.b_x = '0; i1.b_y = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_a_ready", i2.a_ready, 0);
    check("rst_b_ready", i2.b_ready, 0);
    check("rst_alu_start", i2.alu_start, 0);
    check("rst_resp_valid", i2.resp_valid, 0);
    check("rst_alu_sel", i2.alu_sel, 0);
    check("rst_alu_x", i2.alu_x, 0);
    check("rst_alu_op", i2.alu_op, 0);
    check("rst_resp_data", i2.resp_data, 0);
    check("rst_resp_id", i2.resp_id, 0);
    check("rst_d1_resp_valid", i1.resp_valid, 0);

    // 1: A alone, 5+3, latency 2
    i2.a_op = 4'd0; i2.a_x = 128'd5; i2.a_y = 128'd3; i2.a_valid = 1'b1;
    #1;
    check("t1_a_ready_T", i2.a_ready, 1);
    check("t1_b_ready_T", i2.b_ready, 0);
    tick(); i2.a_valid = 1'b0; #1;
    check("t1_start_T1", i2.alu_start, 1);
    check("t1_a_ready_T1", i2.a_ready, 0);
    check("t1_alu_x", i2.alu_x, 5);
    check("t1_alu_sel", i2.alu_sel, 0);
    tick();
    check("t1_start_T2", i2.alu_start, 0);
    check("t1_resp_T2", i2.resp_valid, 0);
    tick();
    check("t1_resp_T3", i2.resp_valid, 0);
    tick();
    check("t1_resp_T4", i2.resp_valid, 1);
    check("t1_resp_id", i2.resp_id, 0);
    check("t1_resp_data", i2.resp_data, 8);
    tick();
    check("t1_resp_T5", i2.resp_valid, 0);
    check("t1_sel_hold_idle", i2.alu_x, 5);
    drain2();

    // 2: both valid continuously, alternation A,B,A,B every 5 cycles
    rst = 1'b1; tick(); rst = 1'b0;
    i2.a_op = 4'd1; i2.a_x = rnd_w(); i2.a_y = rnd_w();
    i2.b_op = 4'd2; i2.b_x = rnd_w(); i2.b_y = rnd_w();
    i2.a_valid = 1'b1; i2.b_valid = 1'b1;
    for (int c = 0; c < 40 && gid.size() < 4; c++) begin
      #1;
      got_g = 1'b0;
      if (i2.a_ready || i2.b_ready) begin
        check("t2_onehot", (i2.a_ready && i2.b_ready), 0);
        acc_b = i2.b_ready;
        gid.push_back(acc_b);
        gcyc.push_back(cyc);
        got_g = 1'b1;
      end
      tick();
      if (got_g) begin
        if (acc_b) begin i2.b_x = rnd_w(); i2.b_y = rnd_w(); end
        else       begin i2.a_x = rnd_w(); i2.a_y = rnd_w(); end
      end
    end
    i2.a_valid = 1'b0; i2.b_valid = 1'b0;
    check("t2_grant_count", gid.size(), 4);
    for (int k = 0; k < gid.size(); k++) check("t2_grant_id", gid[k], k % 2);
    for (int k = 1; k < gcyc.size(); k++) check("t2_grant_gap", gcyc[k] - gcyc[k-1], 5);
    drain2();

    // 3: B alone, A arrives during WAIT and must wait for IDLE
    i2.b_op = 4'd3; i2.b_x = rnd_w(); i2.b_y = rnd_w(); i2.b_valid = 1'b1;
    #1;
    check("t3_b_ready", i2.b_ready, 1);
    check("t3_a_ready_T", i2.a_ready, 0);
    tick(); i2.b_valid = 1'b0;
    tick();
    i2.a_op = 4'd0; i2.a_x = 128'd100; i2.a_y = 128'd23; i2.a_valid = 1'b1;
    #1;
    check("t3_a_ready_wait0", i2.a_ready, 0);
    tick();
    check("t3_a_ready_wait1", i2.a_ready, 0);
    tick();
    check("t3_a_ready_resp", i2.a_ready, 0);
    check("t3_resp_valid", i2.resp_valid, 1);
    check("t3_resp_id", i2.resp_id, 1);
    tick();
    check("t3_a_ready_idle", i2.a_ready, 1);
    tick(); i2.a_valid = 1'b0;
    drain2();

    // 4: reset while waiting drops the op
    i2.a_op = 4'd0; i2.a_x = 128'd7; i2.a_y = 128'd9; i2.a_valid = 1'b1;
    #1;
    check("t4_a_ready", i2.a_ready, 1);
    tick(); i2.a_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q2.delete();
    check("t4_alu_start", i2.alu_start, 0);
    check("t4_resp_valid", i2.resp_valid, 0);
    check("t4_alu_x", i2.alu_x, 0);
    check("t4_alu_sel", i2.alu_sel, 0);
    check("t4_resp_data", i2.resp_data, 0);
    busy_resp = 0;
    for (int c = 0; c < 6; c++) begin
      if (i2.resp_valid) busy_resp++;
      tick();
    end
    check("t4_no_resp_dropped", busy_resp, 0);
    i2.a_x = 128'd40; i2.a_y = 128'd2; i2.a_valid = 1'b1;
    #1;
    check("t4_fresh_ready", i2.a_ready, 1);
    tick(); i2.a_valid = 1'b0;
    repeat (3) tick();
    check("t4_fresh_resp", i2.resp_valid, 1);
    check("t4_fresh_data", i2.resp_data, 42);
    drain2();

    // 5: ALU_LAT=1 instance
    i1.a_op = 4'd1; i1.a_x = 128'd50; i1.a_y = 128'd8; i1.a_valid = 1'b1;
    #1;
    check("t5_a_ready", i1.a_ready, 1);
    tick(); i1.a_valid = 1'b0;
    check("t5_start_T1", i1.alu_start, 1);
    tick();
    check("t5_start_T2", i1.alu_start, 0);
    check("t5_resp_T2", i1.resp_valid, 0);
    tick();
    check("t5_resp_T3", i1.resp_valid, 1);
    check("t5_resp_data", i1.resp_data, 42);
    tick();
    check("t5_resp_T4", i1.resp_valid, 0);
    gid.delete(); gcyc.delete();
    i1.a_op = 4'd2; i1.a_x = rnd_w(); i1.a_y = rnd_w();
    i1.b_op = 4'd0; i1.b_x = rnd_w(); i1.b_y = rnd_w();
    i1.a_valid = 1'b1; i1.b_valid = 1'b1;
    for (int c = 0; c < 30 && gid.size() < 3; c++) begin
      #1;
      if (i1.a_ready || i1.b_ready) begin
        acc_b = i1.b_ready;
        gid.push_back(acc_b);
        gcyc.push_back(cyc);
      end
      tick();
    end
    i1.a_valid = 1'b0; i1.b_valid = 1'b0;
    check("t5_grant_count", gid.size(), 3);
    for (int k = 0; k < gid.size(); k++) check("t5_grant_id", gid[k], (k % 2 == 0) ? 1 : 0);
    for (int k = 1; k < gcyc.size(); k++) check("t5_grant_gap", gcyc[k] - gcyc[k-1], 4);
    drain1();

`ifdef ALU_SHARE_STATS_EN
    // 6: grant counters and saturation
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_cnt_a_rst", gca2, 0);
    req2(1'b0, 4'd0, 128'd1, 128'd1);
    req2(1'b1, 4'd0, 128'd2, 128'd2);
    req2(1'b0, 4'd0, 128'd3, 128'd3);
    req2(1'b1, 4'd0, 128'd4, 128'd4);
    req2(1'b0, 4'd0, 128'd5, 128'd5);
    drain2();
    check("t6_cnt_a", gca2, 3);
    check("t6_cnt_b", gcb2, 2);
    force dut2.grant_cnt_a = 32'hFFFF_FFFF;
    tick();
    release dut2.grant_cnt_a;
    req2(1'b0, 4'd1, 128'd9, 128'd1);
    drain2();
    check("t6_cnt_a_sat", gca2, 32'hFFFF_FFFF);
    check("t6_cnt_b_hold", gcb2, 2);
`endif

    drain2();
    drain1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
